// File: rtl/btn_event_decoder_pkg.sv
// Package: coffee_btn_pkg
// Types and default timing constants shared by the push-button consumers
// of the coffee maker (button event decoder, brew-control FSM, UI timers).
//  btn_fsm_e      : gesture decoder state, 3-bit encoding
//  DEF_*          : default timing for a 50 MHz clock with a 1 ms timebase
package coffee_btn_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    PRESSED   = 3'd1,
    LONG_HELD = 3'd2,
    WAIT2     = 3'd3,
    PRESSED2  = 3'd4
  } btn_fsm_e;

  localparam int DEF_TICK_DIV  = 50000;
  localparam int DEF_LONG_MS   = 1000;
  localparam int DEF_DCLICK_MS = 250;
  localparam int DEF_REPEAT_MS = 200;
  localparam int DEF_CNT_W     = 16;

endpackage

// File: rtl/btn_event_decoder_if.sv
// Interface: btn_event_decoder_if
// Bundles one debounced button (level plus press/release pulses) with the
// user events decoded from it.
//  master : debouncer / test side, drives btn_state, btn_down, btn_up
//  slave  : decoder side, drives short_press, long_press, double_press,
//           repeat_press and busy
interface btn_event_decoder_if;

  logic btn_state;
  logic btn_down;
  logic btn_up;
  logic short_press;
  logic long_press;
  logic double_press;
  logic repeat_press;
  logic busy;

  modport master (
    output btn_state, btn_down, btn_up,
    input  short_press, long_press, double_press, repeat_press, busy
  );

  modport slave (
    input  btn_state, btn_down, btn_up,
    output short_press, long_press, double_press, repeat_press, busy
  );

endinterface

// File: rtl/btn_event_decoder_tick_gen.sv
// Module: btn_tick_gen
// Free-running prescaler producing the 1 ms timebase for the decoder.
//  clk     in  system clock
//  rst_n   in  asynchronous active-low reset, clears the prescaler to 0
//  ms_tick out high for one cycle each time the prescaler wraps
//              (prescaler == TICK_DIV-1)
import coffee_btn_pkg::*;

module btn_tick_gen #(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  output logic ms_tick
);

  localparam int            PRE_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  logic [PRE_W-1:0] prescale;

  // Counts 0..TICK_DIV-1 and wraps; never stops once out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prescale <= '0;
    end else if (prescale == PRE_LAST) begin
      prescale <= '0;
    end else begin
      prescale <= prescale + 1'b1;
    end
  end

  assign ms_tick = (prescale == PRE_LAST);

endmodule

// File: rtl/btn_event_decoder.sv
// Module: btn_event_decoder
// Turns one debounced push button into coffee-maker user events: short
// press, long press, double press and (optionally) auto-repeat while held.
//  clk    in  system clock
//  rst_n  in  asynchronous active-low reset; an in-progress gesture is dropped
//  btn    slave modport of btn_event_decoder_if
//           btn_state/btn_down/btn_up in, event pulses and busy out
// Optional feature macro: BTN_AUTOREPEAT_EN
//  defined   : repeat_press pulses every REPEAT_MS while the button is long-held
//  undefined : repeat logic absent, repeat_press is tied to 0
// All event outputs are registered one-cycle pulses, at most one per cycle.
import coffee_btn_pkg::*;

module btn_event_decoder #(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int LONG_MS   = DEF_LONG_MS,
  parameter int DCLICK_MS = DEF_DCLICK_MS,
  parameter int REPEAT_MS = DEF_REPEAT_MS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input logic          clk,
  input logic          rst_n,
  btn_event_decoder_if.slave btn
);

  localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_MS - 1);
  localparam logic [CNT_W-1:0] DCLICK_LAST = CNT_W'(DCLICK_MS - 1);
`ifdef BTN_AUTOREPEAT_EN
  localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_MS - 1);
`endif

  logic             ms_tick;
  btn_fsm_e         state;
  logic [CNT_W-1:0] ms_cnt;
  logic             short_q;
  logic             long_q;
  logic             double_q;
  logic             down_ev;
  logic             up_ev;

  btn_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk     (clk),
    .rst_n   (rst_n),
    .ms_tick (ms_tick)
  );

  // A press and a release flagged in the same cycle are contradictory, so
  // both are discarded before the FSM sees them.
  assign down_ev = btn.btn_down & ~btn.btn_up;
  assign up_ev   = btn.btn_up   & ~btn.btn_down;

`ifdef BTN_AUTOREPEAT_EN
  logic repeat_q;
`endif

  // Gesture FSM with its ms counter and registered event pulses.
  // The counter increments on each ms tick by default; every transition
  // overrides that with a clear, so ms_cnt always measures time in the
  // current state. Edges are tested before the deciding tick so that an
  // edge arriving on the same cycle as a timeout wins. A level that
  // contradicts the current state (released without btn_up) drops the
  // gesture silently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      ms_cnt   <= '0;
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q <= 1'b0;
`endif
    end else begin
      short_q  <= 1'b0;
      long_q   <= 1'b0;
      double_q <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      repeat_q <= 1'b0;
`endif
      if (ms_tick && (ms_cnt != '1)) begin
        ms_cnt <= ms_cnt + 1'b1;
      end

      case (state)
        IDLE: begin
          if (down_ev) begin
            state  <= PRESSED;
            ms_cnt <= '0;
          end
        end

        PRESSED: begin
          if (up_ev) begin
            state  <= WAIT2;
            ms_cnt <= '0;
          end else if (!btn.btn_state) begin
            state  <= IDLE;
            ms_cnt <= '0;
          end else if (ms_tick && (ms_cnt == LONG_LAST)) begin
            long_q <= 1'b1;
            state  <= LONG_HELD;
            ms_cnt <= '0;
          end
        end

        LONG_HELD: begin
          if (up_ev || !btn.btn_state) begin
            state  <= IDLE;
            ms_cnt <= '0;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (ms_tick && (ms_cnt == REPEAT_LAST)) begin
            repeat_q <= 1'b1;
            ms_cnt   <= '0;
          end
`endif
        end

        WAIT2: begin
          if (down_ev) begin
            state  <= PRESSED2;
            ms_cnt <= '0;
          end else if (ms_tick && (ms_cnt == DCLICK_LAST)) begin
            short_q <= 1'b1;
            state   <= IDLE;
            ms_cnt  <= '0;
          end
        end

        PRESSED2: begin
          if (up_ev) begin
            double_q <= 1'b1;
            state    <= IDLE;
            ms_cnt   <= '0;
          end else if (!btn.btn_state) begin
            state  <= IDLE;
            ms_cnt <= '0;
          end
        end

        default: begin
          state  <= IDLE;
          ms_cnt <= '0;
        end
      endcase
    end
  end

  assign btn.short_press  = short_q;
  assign btn.long_press   = long_q;
  assign btn.double_press = double_q;
  assign btn.busy         = (state != IDLE);
`ifdef BTN_AUTOREPEAT_EN
  assign btn.repeat_press = repeat_q;
`else
  assign btn.repeat_press = 1'b0;
`endif

endmodule

// File: tb/tb_btn_event_decoder.sv
// Testbench: tb_btn_event_decoder
// Directed checks of btn_event_decoder with a fast timebase
// (TICK_DIV=4 -> 1 ms = 4 cycles, LONG_MS=10, DCLICK_MS=5, REPEAT_MS=3).
// A table of whole gestures is applied in a loop and the event counts are
// compared; hand-written sequences pin exact pulse cycles and corner cases.
// Cycle numbering: cyc counts rising edges since reset release, the
// prescaler ticks on edges 4, 8, 12, ... and a pulse decided on edge N is
// seen at the following falling edge with cyc == N.
module tb_btn_event_decoder;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  btn_event_decoder_if bif ();

  btn_event_decoder #(
    .TICK_DIV  (4),
    .LONG_MS   (10),
    .DCLICK_MS (5),
    .REPEAT_MS (3),
    .CNT_W     (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (bif)
  );

  typedef struct {
    int hold1;
    int gap;
    int hold2;
    int exp_short;
    int exp_long;
    int exp_double;
  } gesture_t;

  gesture_t vec [6];

  int cyc;
  int total = 0;
  int bad   = 0;
  int n_short, n_long, n_double, n_repeat, n_multi;
  int last_short, last_long, last_double, last_repeat;
  int b_short, b_long, b_double, b_repeat;

  // Rising-edge counter since the last reset release.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cyc <= 0;
    else        cyc <= cyc + 1;
  end

  // Pulse monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (bif.short_press)  begin n_short  <= n_short + 1;  last_short  <= cyc; end
    if (bif.long_press)   begin n_long   <= n_long + 1;   last_long   <= cyc; end
    if (bif.double_press) begin n_double <= n_double + 1; last_double <= cyc; end
    if (bif.repeat_press) begin n_repeat <= n_repeat + 1; last_repeat <= cyc; end
    if ((int'(bif.short_press) + int'(bif.long_press) + int'(bif.double_press)
         + int'(bif.repeat_press)) > 1)
      n_multi <= n_multi + 1;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic check_output(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic at_cycle(input int n);
    int guard;
    guard = 0;
    while ((cyc < n - 1) && (guard < 2000)) begin
      @(negedge clk);
      guard++;
    end
    check_output("schedule", cyc, n - 1);
  endtask

  task automatic apply_stimulus(input int n, input logic st, input logic dn, input logic up);
    at_cycle(n);
    bif.btn_state = st;
    bif.btn_down  = dn;
    bif.btn_up    = up;
  endtask

  task automatic press_at(input int n);
    apply_stimulus(n, 1'b1, 1'b1, 1'b0);
    apply_stimulus(n + 1, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic release_at(input int n);
    apply_stimulus(n, 1'b0, 1'b0, 1'b1);
    apply_stimulus(n + 1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    bif.btn_state = 1'b0;
    bif.btn_down  = 1'b0;
    bif.btn_up    = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    b_short  = n_short;
    b_long   = n_long;
    b_double = n_double;
    b_repeat = n_repeat;
  endtask

  function automatic int all_events();
    return (n_short - b_short) + (n_long - b_long) + (n_double - b_double)
           + (n_repeat - b_repeat);
  endfunction

  initial begin
    int t;
    vec[0] = '{hold1: 12, gap: 0,  hold2: 0,  exp_short: 1, exp_long: 0, exp_double: 0};
    vec[1] = '{hold1: 32, gap: 0,  hold2: 0,  exp_short: 1, exp_long: 0, exp_double: 0};
    vec[2] = '{hold1: 48, gap: 0,  hold2: 0,  exp_short: 0, exp_long: 1, exp_double: 0};
    vec[3] = '{hold1: 8,  gap: 8,  hold2: 8,  exp_short: 0, exp_long: 0, exp_double: 1};
    vec[4] = '{hold1: 8,  gap: 28, hold2: 8,  exp_short: 2, exp_long: 0, exp_double: 0};
    vec[5] = '{hold1: 8,  gap: 8,  hold2: 60, exp_short: 0, exp_long: 0, exp_double: 1};

    bif.btn_state = 1'b0;
    bif.btn_down  = 1'b0;
    bif.btn_up    = 1'b0;
    repeat (2) @(negedge clk);
    check_output("reset_outputs",
                 int'({bif.short_press, bif.long_press, bif.double_press,
                       bif.repeat_press, bif.busy}), 0);

    // Whole gestures, compared by event count once everything settled.
    for (int i = 0; i < 6; i++) begin
      do_reset();
      press_at(5);
      t = 5 + vec[i].hold1;
      release_at(t);
      if (vec[i].hold2 > 0) begin
        t = t + vec[i].gap;
        press_at(t);
        t = t + vec[i].hold2;
        release_at(t);
      end
      at_cycle(t + 100);
      $display("[TB] gesture %0d applied", i);
      check_output("vec_short",  n_short - b_short,   vec[i].exp_short);
      check_output("vec_long",   n_long - b_long,     vec[i].exp_long);
      check_output("vec_double", n_double - b_double, vec[i].exp_double);
      check_output("vec_repeat", n_repeat - b_repeat, 0);
      check_output("vec_busy",   int'(bif.busy),      0);
    end

    // Short press: released on edge 17, timeout on the 5th tick after (edge 36).
    do_reset();
    press_at(5);
    release_at(17);
    at_cycle(20);
    check_output("short_busy_wait2", int'(bif.busy), 1);
    at_cycle(100);
    check_output("short_count", n_short - b_short, 1);
    check_output("short_cycle", last_short, 36);
    check_output("short_others", all_events(), 1);

    // Release on the very tick that would make it long: release wins.
    do_reset();
    press_at(5);
    release_at(44);
    at_cycle(120);
    check_output("edge_wins_long", n_long - b_long, 0);
    check_output("edge_wins_short", n_short - b_short, 1);
    check_output("edge_wins_cycle", last_short, 64);

    // Release one cycle after the long tick: long press, nothing else.
    do_reset();
    press_at(5);
    at_cycle(30);
    check_output("long_busy_held", int'(bif.busy), 1);
    release_at(45);
    at_cycle(50);
    check_output("long_busy_drop", int'(bif.busy), 0);
    at_cycle(120);
    check_output("long_count", n_long - b_long, 1);
    check_output("long_cycle", last_long, 44);
    check_output("long_no_short", n_short - b_short, 0);

    // Double press: second release on edge 29, pulse seen right after it.
    do_reset();
    press_at(5);
    release_at(13);
    press_at(21);
    release_at(29);
    at_cycle(100);
    check_output("double_count", n_double - b_double, 1);
    check_output("double_cycle", last_double, 29);
    check_output("double_no_short", n_short - b_short, 0);

    // Hold 20 ms: long at 10 ms, repeats at 13/16/19 ms only with the macro.
    do_reset();
    press_at(5);
    release_at(85);
    at_cycle(150);
    check_output("hold_long_cycle", last_long, 44);
`ifdef BTN_AUTOREPEAT_EN
    check_output("repeat_count", n_repeat - b_repeat, 3);
    check_output("repeat_last", last_repeat, 80);
`else
    check_output("repeat_count", n_repeat - b_repeat, 0);
`endif
    check_output("hold_no_short", n_short - b_short, 0);

    // Reset in the middle of a press drops the gesture.
    do_reset();
    press_at(5);
    at_cycle(12);
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("midreset_outputs",
                 int'({bif.short_press, bif.long_press, bif.double_press,
                       bif.repeat_press, bif.busy}), 0);
    rst_n = 1'b1;
    release_at(5);
    at_cycle(80);
    check_output("midreset_events", all_events(), 0);
    check_output("midreset_busy", int'(bif.busy), 0);

    // Level drops without a release pulse: silently back to idle.
    do_reset();
    press_at(5);
    apply_stimulus(13, 1'b0, 1'b0, 1'b0);
    at_cycle(15);
    check_output("resync_busy", int'(bif.busy), 0);
    at_cycle(80);
    check_output("resync_events", all_events(), 0);

    // Press and release flagged together are ignored, in idle and while held.
    do_reset();
    apply_stimulus(5, 1'b1, 1'b1, 1'b1);
    apply_stimulus(6, 1'b0, 1'b0, 1'b0);
    at_cycle(8);
    check_output("both_idle_busy", int'(bif.busy), 0);
    press_at(10);
    apply_stimulus(15, 1'b1, 1'b1, 1'b1);
    apply_stimulus(16, 1'b1, 1'b0, 1'b0);
    at_cycle(18);
    check_output("both_pressed_busy", int'(bif.busy), 1);
    release_at(20);
    at_cycle(100);
    check_output("both_short", n_short - b_short, 1);
    check_output("both_events", all_events(), 1);

    check_output("one_pulse_per_cycle", n_multi, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
